// File: rtl/mipi_hs_lane_serializer_if.sv
// mipi_hs_lane_serializer_if: word handshake, burst control and line outputs of one HS data lane
interface mipi_hs_lane_serializer_if #(
  parameter int WIDTH = 8
);
  logic             HS_SER_EN;
  logic [WIDTH-1:0] HSTX_DATA;
  logic             HSTX_VALID;
  logic             HSTX_LAST;
  logic             HSTX_READY;
  logic             DTXHS;
  logic             HS_ACTIVE;
  logic             HS_UNDERFLOW;
  logic             HS_DONE;
  modport master (
    output HS_SER_EN, HSTX_DATA, HSTX_VALID, HSTX_LAST,
    input  HSTX_READY, DTXHS, HS_ACTIVE, HS_UNDERFLOW, HS_DONE
  );
  modport slave (
    input  HS_SER_EN, HSTX_DATA, HSTX_VALID, HSTX_LAST,
    output HSTX_READY, DTXHS, HS_ACTIVE, HS_UNDERFLOW, HS_DONE
  );
endinterface

// File: rtl/mipi_hs_lane_serializer.sv
// mipi_hs_lane_serializer: frames and serializes HS bursts (zero, sync, payload, trail) for one D-PHY lane
module mipi_hs_lane_serializer #(
  parameter int         WIDTH      = 8,
  parameter int         ZERO_BITS  = 8,
  parameter int         TRAIL_BITS = 16,
  parameter logic [7:0] SYNC_WORD  = 8'hB8,
  parameter bit         LSB_FIRST  = 1'b1
) (
  input logic HS_TXCLK,
  input logic HS_RST,
  mipi_hs_lane_serializer_if.slave bus
);
  localparam int M1 = ZERO_BITS > TRAIL_BITS ? ZERO_BITS : TRAIL_BITS;
  localparam int M2 = WIDTH > 8 ? WIDTH : 8;
  localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
  localparam logic [CW-1:0] Z_END = CW'(ZERO_BITS - 1);
  localparam logic [CW-1:0] T_END = CW'(TRAIL_BITS - 1);
  localparam logic [CW-1:0] W_END = CW'(WIDTH - 1);
  localparam logic [CW-1:0] S_END = CW'(7);
  // sync word is parked at the end of the register that shifts out first
  localparam logic [WIDTH-1:0] SYNC_LD = LSB_FIRST ? WIDTH'(SYNC_WORD) : WIDTH'(SYNC_WORD) << (WIDTH - 8);
  typedef enum logic [2:0] {IDLE, ZERO, SYNC, DATA, TRAIL} state_t;
  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic             last_q, last_n, lb, lb_n, bit_v, word_end, ready, take, dtx, act;
  assign word_end         = (state == SYNC && cnt == S_END) || (state == DATA && cnt == W_END);
  assign ready            = word_end & bus.HS_SER_EN & ~last_q;
  assign take             = ready & bus.HSTX_VALID;
  assign bus.HSTX_READY   = ready;
  assign bus.HS_UNDERFLOW = ready & ~bus.HSTX_VALID;
  assign bus.HS_DONE      = state == TRAIL && cnt == T_END;
  assign bus.DTXHS        = dtx;
  assign bus.HS_ACTIVE    = act;
  // next state, shift value and word fetch; every word boundary either loads the next word or falls into trail
  always_comb begin
    nxt    = state;
    cnt_n  = cnt + 1'b1;
    sr_n   = LSB_FIRST ? sr >> 1 : sr << 1;
    last_n = last_q;
    lb_n   = lb;
    bit_v  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        last_n = 1'b0;
        nxt    = bus.HS_SER_EN ? ZERO : IDLE;
      end
      ZERO: if (cnt == Z_END) begin
        cnt_n = '0;
        sr_n  = SYNC_LD;
        nxt   = SYNC;
      end
      SYNC, DATA: begin
        bit_v = LSB_FIRST ? sr[0] : sr[WIDTH-1];
        lb_n  = bit_v;
        if (word_end) begin
          cnt_n  = '0;
          nxt    = take ? DATA : TRAIL;
          sr_n   = take ? bus.HSTX_DATA : sr_n;
          last_n = take ? bus.HSTX_LAST : last_q;
        end
      end
      TRAIL: begin
        bit_v = ~lb;
        if (cnt == T_END) begin
          cnt_n = '0;
          nxt   = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  // state, counters and the line flops; active is delayed with the data so it brackets the bits on the line
  always_ff @(posedge HS_TXCLK or posedge HS_RST) begin
    if (HS_RST) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      last_q <= 1'b0;
      lb     <= 1'b0;
      dtx    <= 1'b0;
      act    <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_n;
      sr     <= sr_n;
      last_q <= last_n;
      lb     <= lb_n;
      dtx    <= bit_v;
      act    <= state != IDLE;
    end
  end
endmodule

// File: tb/tb_mipi_hs_lane_serializer.sv
// tb_mipi_hs_lane_serializer: scoreboard bench for 8-bit LSB-first and 16-bit MSB-first serializers
module tb_mipi_hs_lane_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mipi_hs_lane_serializer_if #(.WIDTH(8))  i8 ();
  mipi_hs_lane_serializer_if #(.WIDTH(16)) i16 ();
  mipi_hs_lane_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .HS_TXCLK(clk), .HS_RST(rst), .bus(i8.slave)
  );
  mipi_hs_lane_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) dut16 (
    .HS_TXCLK(clk), .HS_RST(rst), .bus(i16.slave)
  );
  int total = 0;
  int bad = 0;
  bit q0[$];
  bit q1[$];
  int n_rdy[2], n_und[2], n_done[2], n_act[2];
  bit skip0 = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  // monitor: pops one expected line bit per active cycle and tallies the status pulses
  task automatic mon(input int k, input logic d, input logic a, input logic r, input logic u, input logic dn);
    bit e;
    if (r) n_rdy[k]++;
    if (u) n_und[k]++;
    if (dn) n_done[k]++;
    if (u) chk($sformatf("under_without_ready%0d", k), r, 1);
    if (!a) begin
      chk($sformatf("idle_dtx%0d", k), d, 0);
      return;
    end
    n_act[k]++;
    if (k == 0 && skip0) return;
    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
      chk($sformatf("extra_active_bit%0d", k), 1, 0);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("dtx%0d", k), d, e);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, i8.DTXHS, i8.HS_ACTIVE, i8.HSTX_READY, i8.HS_UNDERFLOW, i8.HS_DONE);
      mon(1, i16.DTXHS, i16.HS_ACTIVE, i16.HSTX_READY, i16.HS_UNDERFLOW, i16.HS_DONE);
    end
  end
  // reference: the whole burst as a bit list built from the framing rules
  task automatic model(input int k, input int mode, input int n, input logic [15:0] w [8], output int len, output int rdy);
    bit bits[$];
    logic [7:0] s;
    int wd;
    bit lastb;
    s = 8'hB8;
    wd = k ? 16 : 8;
    repeat (8) bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(k ? s[7-i] : s[i]);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < wd; i++) bits.push_back(k ? w[j][wd-1-i] : w[j][i]);
    lastb = bits[$];
    repeat (16) bits.push_back(~lastb);
    len = bits.size();
    foreach (bits[i]) begin
      if (k) q1.push_back(bits[i]);
      else q0.push_back(bits[i]);
    end
    rdy = mode == 1 ? n + 1 : n;
  endtask
  task automatic drive(input int k, input logic en, input logic v, input logic [15:0] d, input logic l);
    if (k) begin
      i16.HS_SER_EN = en; i16.HSTX_VALID = v; i16.HSTX_DATA = d; i16.HSTX_LAST = l;
    end else begin
      i8.HS_SER_EN = en; i8.HSTX_VALID = v; i8.HSTX_DATA = d[7:0]; i8.HSTX_LAST = l;
    end
  endtask
  task automatic wait_slot(input int k);
    int t;
    logic r;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      r = k ? i16.HSTX_READY : i8.HSTX_READY;
    end while (!r && t < 300);
    chk($sformatf("ready_slot%0d", k), r, 1);
    @(posedge clk);
    #1;
  endtask
  // mode 0: last word flagged, 1: valid drops after n words, 2: enable drops after n words
  task automatic burst(input int k, input int mode, input int n, input logic [15:0] w [8]);
    int len, rdy, t;
    model(k, mode, n, w, len, rdy);
    n_rdy[k] = 0; n_und[k] = 0; n_done[k] = 0; n_act[k] = 0;
    drive(k, 1'b1, n > 0, w[0], mode == 0 && n == 1);
    for (int i = 0; i < n; i++) begin
      drive(k, 1'b1, 1'b1, w[i], mode == 0 && i == n - 1);
      wait_slot(k);
    end
    if (mode == 1) begin
      drive(k, 1'b1, 1'b0, 16'h0, 1'b0);
      wait_slot(k);
    end else if (mode == 2 && n == 0) begin
      repeat (10) @(posedge clk);
      #1;
    end
    drive(k, 1'b0, 1'b0, 16'h0, 1'b0);
    t = 0;
    while (n_done[k] == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("done_pulses%0d_m%0d", k, mode), n_done[k], 1);
    chk($sformatf("active_len%0d_m%0d", k, mode), n_act[k], len);
    chk($sformatf("ready_count%0d_m%0d", k, mode), n_rdy[k], rdy);
    chk($sformatf("underflow%0d_m%0d", k, mode), n_und[k], mode == 1);
    chk($sformatf("bits_left%0d", k), k ? q1.size() : q0.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_dtx"}, i8.DTXHS, 0);
    chk({nm, "_ready"}, i8.HSTX_READY, 0);
    chk({nm, "_active"}, i8.HS_ACTIVE, 0);
    chk({nm, "_under"}, i8.HS_UNDERFLOW, 0);
    chk({nm, "_done"}, i8.HS_DONE, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    logic [15:0] w [8];
    int mode, n;
    drive(0, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 1'b0);
    #12;
    chk_zero("reset");
    chk("reset16_active", i16.HS_ACTIVE, 0);
    chk("reset16_dtx", i16.DTXHS, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (w[i]) w[i] = 16'h0;
    w[0] = 16'hA5;
    burst(0, 0, 1, w);
    w[0] = 16'h01; w[1] = 16'h80; w[2] = 16'hFF;
    burst(0, 0, 3, w);
    w[0] = 16'h0F;
    burst(0, 1, 1, w);
    burst(0, 2, 0, w);
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 2);
      n = mode == 2 ? $urandom_range(0, 3) : $urandom_range(1, 4);
      foreach (w[i]) w[i] = 16'($urandom);
      burst(0, mode, n, w);
    end
    w[0] = 16'h8001;
    burst(1, 0, 1, w);
    for (int r = 0; r < 3; r++) begin
      mode = $urandom_range(0, 2);
      n = mode == 2 ? $urandom_range(0, 3) : $urandom_range(1, 3);
      foreach (w[i]) w[i] = 16'($urandom);
      burst(1, mode, n, w);
    end
    skip0 = 1'b1;
    drive(0, 1'b1, 1'b1, 16'h3C, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    skip0 = 1'b0;
    w[0] = 16'h5A;
    burst(0, 0, 1, w);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
